// File: rtl/button_press_detect_pkg.sv
// Shared types and helpers for the push-button conditioning block.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_press_detect_if.sv
// Button pin in, conditioned level and event strobes out.
interface button_press_detect_if ();
  logic btn;
  logic level;
  logic press;
  logic released;
  logic short_press;
  logic long_press;

  modport master (
    output btn,
    input  level, press, released, short_press, long_press
  );

  modport slave (
    input  btn,
    output level, press, released, short_press, long_press
  );
endinterface

// File: rtl/button_press_detect_debounce.sv
// Two-flop synchronizer plus stability counter producing a debounced level.
module debounce_filter
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic          sync_p0;
  logic          sync_p1;
  logic          s;
  logic          toggle;
  logic [DW-1:0] db_cnt;

  // Synchronizer flops idle at the inactive pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= ACTIVE_LOW;
      sync_p1 <= ACTIVE_LOW;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  assign s      = sync_p1 ^ ACTIVE_LOW;
  assign toggle = (s != level) && (db_cnt == DB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  // Stability counter: any sample matching the current level restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (s == level) begin
      db_cnt <= '0;
    end else if (toggle) begin
      level  <= ~level;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/button_press_detect.sv
// Debounced button with press/release strobes and short/long press classification.
module button_press_detect
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_press_detect_if.slave bus
);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end

  logic          level;
  logic          rise;
  logic          fall;
  state_t        state_q;
  state_t        state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          short_d;
  logic          long_d;
  logic          press_q;
  logic          rel_q;
  logic          short_q;
  logic          long_q;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // A release always wins over reaching the long threshold on the same edge
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = DOWN;
          hold_d  = '0;
        end
      end
      DOWN: begin
        if (fall) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe registers and FSM state share the LEVEL update edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      press_q <= rise;
      rel_q   <= fall;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign bus.level       = level;
  assign bus.press       = press_q;
  assign bus.released    = rel_q;
  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;

endmodule

// File: tb/tb_button_press_detect.sv
// Randomized scenario bench for button_press_detect against a timestamp-based reference model.
module tb_button_press_detect;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_press_detect_if bus_a ();
  button_press_detect_if bus_b ();

  button_press_detect #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  button_press_detect #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic [4:0] obs_a, obs_b;
  assign obs_a = {bus_a.level, bus_a.press, bus_a.released, bus_a.short_press, bus_a.long_press};
  assign obs_b = {bus_b.level, bus_b.press, bus_b.released, bus_b.short_press, bus_b.long_press};

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  // Reference model: per-edge normalized pin samples, level and press timestamps
  bit         hist [2][HN];
  int         hp [2];
  bit         m_lvl [2];
  int         last_flip [2];
  int         press_t [2];
  logic [4:0] exp_v [2];

  function automatic bit hget(input int i, input int back);
    return hist[i][(hp[i] - 1 - back) % HN];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i]     = 1'b0;
      last_flip[i] = -1000;
      press_t[i]   = -1000;
      exp_v[i]     = '0;
      for (int k = 0; k < D + 2; k++) begin
        hist[i][hp[i] % HN] = 1'b0;
        hp[i]++;
      end
    end
  endtask

  // Level flips once the last D synchronized samples all disagree with it and
  // at least D edges have passed since the previous flip.
  task automatic model_update();
    bit raw, differ, flip, rise, fall, sp, lp;
    ecnt++;
    if (!rst_n) begin
      exp_v[0] = '0;
      exp_v[1] = '0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      raw = (i == 0) ? bus_a.btn : bus_b.btn;
      hist[i][hp[i] % HN] = raw ^ (i == 1);
      hp[i]++;
      differ = 1'b1;
      for (int b = 2; b <= D + 1; b++)
        if (hget(i, b) == m_lvl[i]) differ = 1'b0;
      flip = differ && (ecnt - last_flip[i] >= D);
      rise = flip && !m_lvl[i];
      fall = flip && m_lvl[i];
      if (flip) begin
        m_lvl[i]     = !m_lvl[i];
        last_flip[i] = ecnt;
      end
      if (rise) press_t[i] = ecnt;
      sp = fall && (ecnt - press_t[i] <= L);
      lp = !flip && m_lvl[i] && (ecnt - press_t[i] == L);
      exp_v[i] = {m_lvl[i], rise, fall, sp, lp};
    end
  endtask

  task automatic test_reset();
    bus_a.btn = 1'b0;
    bus_b.btn = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== 10'b0) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got %b want %b", c, {obs_a, obs_b}, 10'b0);
      end
    end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
    end
  endtask

  task automatic test_short_press();
    int p_edge, shorts, longs, rels, hold;
    for (int n = 0; n < 4; n++) begin
      hold   = (n == 0) ? 10 : int'($urandom_range(D + 2, L - 3));
      p_edge = -1; shorts = 0; longs = 0; rels = 0;
      bus_a.btn = 1'b1;
      for (int c = 1; c <= hold + D + 12; c++) begin
        @(posedge clk); model_update(); @(negedge clk);
        checks++;
        if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
          errors++;
          $display("FAIL short_press hold %0d cyc %0d: got %b want %b", hold, c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
        end
        if (bus_a.press === 1'b1) p_edge = c;
        shorts += int'(bus_a.short_press === 1'b1);
        longs  += int'(bus_a.long_press === 1'b1);
        rels   += int'(bus_a.released === 1'b1);
        if (c == hold) bus_a.btn = 1'b0;
      end
      checks++;
      if (p_edge != D + 2) begin
        errors++;
        $display("FAIL short_latency: press at edge %0d want %0d", p_edge, D + 2);
      end
      checks++;
      if (shorts != 1 || longs != 0 || rels != 1) begin
        errors++;
        $display("FAIL short_class: short=%0d long=%0d rel=%0d want 1 0 1", shorts, longs, rels);
      end
    end
  endtask

  task automatic test_bounce();
    int p_edge, presses;
    p_edge = -1; presses = 0;
    bus_a.btn = 1'b1;
    for (int c = 1; c <= 12 + D + 8; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL bounce cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      if (bus_a.press === 1'b1) begin p_edge = c; presses++; end
      bus_a.btn = (c < 12) ? (((c / 2) % 2) == 0) : 1'b1;
    end
    checks++;
    if (p_edge != 12 + D + 2 || presses != 1) begin
      errors++;
      $display("FAIL bounce_latency: press at edge %0d count %0d want edge %0d count 1", p_edge, presses, 12 + D + 2);
    end
    // Random chatter, then a settled release
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL chatter cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      if (c < 110) begin
        if ($urandom_range(0, 3) == 0) bus_a.btn = ~bus_a.btn;
      end else begin
        bus_a.btn = 1'b0;
      end
    end
  endtask

  task automatic test_long_press();
    int p_edge, l_edge, shorts, longs, rels;
    p_edge = -1; l_edge = -1; shorts = 0; longs = 0; rels = 0;
    bus_a.btn = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL long_press cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      if (bus_a.press === 1'b1) p_edge = c;
      if (bus_a.long_press === 1'b1) begin l_edge = c; longs++; end
      shorts += int'(bus_a.short_press === 1'b1);
      rels   += int'(bus_a.released === 1'b1);
      if (c == 40) bus_a.btn = 1'b0;
    end
    checks++;
    if (longs != 1 || l_edge - p_edge != L) begin
      errors++;
      $display("FAIL long_timing: long count %0d at +%0d want 1 at +%0d", longs, l_edge - p_edge, L);
    end
    checks++;
    if (shorts != 0 || rels != 1) begin
      errors++;
      $display("FAIL long_release: short=%0d rel=%0d want 0 1", shorts, rels);
    end
  endtask

  task automatic test_boundary();
    int offs [3] = '{L, L + 1, L - 1};
    int p_edge, r_edge, shorts, longs;
    for (int n = 0; n < 3; n++) begin
      p_edge = -1; r_edge = -1; shorts = 0; longs = 0;
      bus_a.btn = 1'b1;
      for (int c = 1; c <= D + L + 16; c++) begin
        @(posedge clk); model_update(); @(negedge clk);
        checks++;
        if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
          errors++;
          $display("FAIL boundary off %0d cyc %0d: got %b want %b", offs[n], c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
        end
        if (bus_a.press === 1'b1) p_edge = c;
        if (bus_a.released === 1'b1) r_edge = c;
        shorts += int'(bus_a.short_press === 1'b1);
        longs  += int'(bus_a.long_press === 1'b1);
        if (p_edge > 0 && c == p_edge + offs[n] - D - 2) bus_a.btn = 1'b0;
      end
      checks++;
      if (r_edge - p_edge != offs[n] || shorts != int'(offs[n] <= L) || longs != int'(offs[n] > L)) begin
        errors++;
        $display("FAIL boundary_class off %0d: fall +%0d short=%0d long=%0d want +%0d %0d %0d",
                 offs[n], r_edge - p_edge, shorts, longs, offs[n], int'(offs[n] <= L), int'(offs[n] > L));
      end
    end
  endtask

  task automatic test_polarity();
    int strobes, p_edge;
    strobes = 0; p_edge = -1;
    bus_b.btn = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL polarity_idle cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      strobes += int'(obs_b !== 5'b0);
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL polarity_quiet: %0d active cycles want 0", strobes);
    end
    bus_b.btn = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL polarity cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      if (bus_b.press === 1'b1) p_edge = c;
      if (c == 12) bus_b.btn = 1'b1;
    end
    checks++;
    if (p_edge != D + 2) begin
      errors++;
      $display("FAIL polarity_latency: press at edge %0d want %0d", p_edge, D + 2);
    end
  endtask

  task automatic test_reset_mid_hold();
    int p_edge, l_edge, longs;
    longs = 0;
    bus_a.btn = 1'b1;
    bus_b.btn = 1'b0;
    for (int c = 1; c <= D + L + 10; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL hold_pre cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      longs += int'(bus_a.long_press === 1'b1);
    end
    checks++;
    if (longs != 1 || bus_a.level !== 1'b1) begin
      errors++;
      $display("FAIL hold_enter_long: long count %0d level %b want 1 1", longs, bus_a.level);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_a, obs_b} !== 10'b0) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", {obs_a, obs_b}, 10'b0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== 10'b0) begin
        errors++;
        $display("FAIL reset_held cyc %0d: got %b want %b", c, {obs_a, obs_b}, 10'b0);
      end
    end
    rst_n = 1'b1;
    model_reset();
    p_edge = -1; l_edge = -1;
    for (int c = 1; c <= D + L + 30; c++) begin
      @(posedge clk); model_update(); @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {exp_v[0], exp_v[1]}) begin
        errors++;
        $display("FAIL hold_post cyc %0d: got %b want %b", c, {obs_a, obs_b}, {exp_v[0], exp_v[1]});
      end
      if (bus_a.press === 1'b1) p_edge = c;
      if (bus_a.long_press === 1'b1) l_edge = c;
      if (c == D + L + 10) begin
        bus_a.btn = 1'b0;
        bus_b.btn = 1'b1;
      end
    end
    checks++;
    if (p_edge != D + 2 || l_edge != D + 2 + L) begin
      errors++;
      $display("FAIL reset_repress: press %0d long %0d want %0d %0d", p_edge, l_edge, D + 2, D + 2 + L);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_bounce();
    test_long_press();
    test_boundary();
    test_polarity();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
